// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung wide-add sequencer: slice width and FSM state encoding.
package bk_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } bk_seq_state_t;

endpackage

// File: rtl/bk_wide_add_seq.sv
// Sequences an OPW-bit add through one external 16-bit adder, one slice per cycle, LSB first.
// Optional macro BK_SEQ_SUB_EN adds an in_sub port for A-B via inverted B and forced carry-in.
module bk_wide_add_seq
  import bk_pkg::*;
#(
  parameter int OPW = 32  // multiple of SLICE_W, at least SLICE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPW-1:0]     in_a,
  input  logic [OPW-1:0]     in_b,
  input  logic               in_cin,
`ifdef BK_SEQ_SUB_EN
  input  logic               in_sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPW-1:0]     out_sum,
  output logic               out_cout,
  output logic [SLICE_W-1:0] add_a,
  output logic [SLICE_W-1:0] add_b,
  output logic               add_cin,
  input  logic [SLICE_W-1:0] add_sum,
  input  logic               add_cout
);

  localparam int NSLICE = OPW / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  bk_seq_state_t    state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [OPW-1:0]   a_reg, b_reg, sum_reg;
  logic             carry_reg;
  logic             accept;
  logic [OPW-1:0]   b_load;
  logic             carry_load;

  assign accept = in_valid && in_ready;

`ifdef BK_SEQ_SUB_EN
  // Two's-complement subtract: A + ~B + 1, so the caller's carry-in is overridden.
  assign b_load     = in_sub ? ~in_b : in_b;
  assign carry_load = in_sub ? 1'b1 : in_cin;
`else
  assign b_load     = in_b;
  assign carry_load = in_cin;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: assign defaults first in always_comb so no path leaves a signal unassigned (latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: data registers are reset too, so out_sum/out_cout read 0 from reset rather than X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= in_a;
            b_reg     <= b_load;
            carry_reg <= carry_load;
            idx       <= '0;
          end
        end
        RUN: begin
          for (int s = 0; s < NSLICE; s++) begin
            if (idx == IDX_W'(s)) sum_reg[s*SLICE_W +: SLICE_W] <= add_sum;
          end
          carry_reg <= add_cout;
          idx       <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Adder operands are only presented during RUN; the path through the adder is single-cycle.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      for (int s = 0; s < NSLICE; s++) begin
        if (idx == IDX_W'(s)) begin
          add_a = a_reg[s*SLICE_W +: SLICE_W];
          add_b = b_reg[s*SLICE_W +: SLICE_W];
        end
      end
      add_cin = carry_reg;
    end
  end

  assign out_valid = (state == DONE);
  assign out_sum   = out_valid ? sum_reg : '0;
  assign out_cout  = out_valid ? carry_reg : 1'b0;
  // Gated with rst_n so the source never sees a handshake while reset is held.
  assign in_ready  = rst_n && (state == IDLE);

endmodule

// File: tb/tb_bk_wide_add_seq.sv
// Directed bench for bk_wide_add_seq (OPW=32) with a behavioural 16-bit adder on the add_* ports.
module tb_bk_wide_add_seq;

  localparam int OPW = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_a;
  logic [OPW-1:0]  in_b;
  logic            in_cin;
  logic            in_sub;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  out_sum;
  logic            out_cout;
  logic [15:0]     add_a;
  logic [15:0]     add_b;
  logic            add_cin;
  logic [15:0]     add_sum;
  logic            add_cout;

  int checks;
  int failures;

  bk_wide_add_seq #(.OPW(OPW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef BK_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // Behavioural stand-in for the Brent-Kung adder.
  logic [16:0] adder_full;
  assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};
  assign add_sum    = adder_full[15:0];
  assign add_cout   = adder_full[16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair from IDLE and let the accepting edge pass.
  task automatic start_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic cin);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) check({tag, "_timeout"}, 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Pipelined-source table: hand-computed sums.
  logic [OPW-1:0] q_a   [3] = '{32'h8000_0000, 32'h0001_FFFF, 32'hDEAD_BEEF};
  logic [OPW-1:0] q_b   [3] = '{32'h8000_0000, 32'h0000_FFFF, 32'h0101_0101};
  logic           q_cin [3] = '{1'b0, 1'b1, 1'b0};
  logic [OPW-1:0] q_sum [3] = '{32'h0000_0000, 32'h0002_FFFF, 32'hDFAE_BFF0};
  logic           q_co  [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    int seen;
    int budget;
    logic accepted;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;

    #2;
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum",   64'(out_sum),   64'd0);
    check("rst_add_a",     64'(add_a),     64'd0);
    #10 rst_n = 1'b1;
    step();
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Carry across the slice boundary; latency of exactly two cycles.
    start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0);
    check("t1_run0_valid", 64'(out_valid), 64'd0);
    check("t1_run0_add_a", 64'(add_a),     64'h0000_FFFF);
    step();
    check("t1_run1_valid", 64'(out_valid), 64'd0);
    step();
    check("t1_done_valid", 64'(out_valid), 64'd1);
    check("t1_sum",        64'(out_sum),   64'h0001_0000);
    check("t1_cout",       64'(out_cout),  64'd0);
    check("t1_done_add_a", 64'(add_a),     64'd0);
    drain();

    // Carry-in ripples all the way out.
    start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    check("t2_run0_cin", 64'(add_cin), 64'd1);
    step();
    check("t2_run1_cin", 64'(add_cin), 64'd1);
    wait_done("t2");
    check("t2_sum",  64'(out_sum),  64'h0000_0000);
    check("t2_cout", 64'(out_cout), 64'd1);

    // Back-pressure in DONE: everything holds, then in_ready one cycle after the handshake.
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_sum",   64'(out_sum),   64'h0000_0000);
      check("t3_hold_cout",  64'(out_cout),  64'd1);
      check("t3_hold_ready", 64'(in_ready),  64'd0);
    end
    drain();
    check("t3_post_valid", 64'(out_valid), 64'd0);
    check("t3_post_ready", 64'(in_ready),  64'd1);

    // Reset mid-RUN aborts the operation.
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_valid", 64'(out_valid), 64'd0);
    check("t4_rst_ready", 64'(in_ready),  64'd0);
    check("t4_rst_add_a", 64'(add_a),     64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("t4_no_valid", 64'(seen), 64'd0);
    check("t4_ready",    64'(in_ready), 64'd1);
    start_op(32'h0000_0001, 32'h0000_0002, 1'b0);
    wait_done("t4b");
    check("t4_sum",  64'(out_sum),  64'h0000_0003);
    check("t4_cout", 64'(out_cout), 64'd0);
    drain();

`ifdef BK_SEQ_SUB_EN
    in_sub = 1'b1;
    start_op(32'h0000_0005, 32'h0000_0007, 1'b0);
    wait_done("t5a");
    check("t5a_sum",  64'(out_sum),  64'hFFFF_FFFE);
    check("t5a_cout", 64'(out_cout), 64'd0);
    drain();
    start_op(32'h0000_0007, 32'h0000_0005, 1'b0);
    wait_done("t5b");
    check("t5b_sum",  64'(out_sum),  64'h0000_0002);
    check("t5b_cout", 64'(out_cout), 64'd1);
    drain();
    in_sub = 1'b0;
`endif

    // Source holds in_valid across three pairs while the sink stalls at random.
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          in_a     = q_a[i];
          in_b     = q_b[i];
          in_cin   = q_cin[i];
          in_valid = 1'b1;
          budget   = 0;
          do begin
            accepted = in_ready;
            step();
            budget++;
          end while (!accepted && budget < 200);
          if (!accepted) check("t6_accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
      end
      begin
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 500) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            check("t6_sum",  64'(out_sum),  64'(q_sum[got]));
            check("t6_cout", 64'(out_cout), 64'(q_co[got]));
            got++;
          end
          step();
          cyc++;
        end
        out_ready = 1'b0;
        check("t6_count", 64'(got), 64'd3);
        for (int i = 0; i < 6; i++) begin
          step();
          if (out_valid) got++;
        end
        check("t6_no_dup", 64'(got), 64'd3);
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
